mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_mem_array.sv | 29 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for mem_arbiter: FSM state encoding, default geometry
// and the port-index width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 32768;

    // Bits needed to hold a port index; never narrower than one bit.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_mem_array.sv
// mem_array: single-port synchronous RAM, DEPTH x DATA_W, one-cycle read latency.
module mem_array
    import mem_arb_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_PORTS requesters share one RAM; port 0 (video) always wins.
// Define MEM_ARB_RR_EN for round-robin among ports 1..N-1, otherwise lowest index wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata
);

    localparam int PW     = port_idx_w(NUM_PORTS);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1    = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     win_nxt;
    logic              pick_found;
    logic              rd_oob;
    logic [DATA_W-1:0] rdata_hold;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              we_sel;
    logic              oob_sel;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

`ifdef MEM_ARB_RR_EN
    logic [PW-1:0]     rr_ptr;

    // rr_ptr is the first port examined in the next search among ports 1..N-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= PW'(1);
        end else if (state == GRANT && win_idx != '0) begin
            rr_ptr <= (win_idx == PW'(NUM_PORTS - 1)) ? PW'(1) : win_idx + PW'(1);
        end
    end
`endif

    always_comb begin
        win_nxt    = '0;
        pick_found = 1'b0;
`ifdef MEM_ARB_RR_EN
        for (int i = 1; i < NUM_PORTS; i++) begin
            if (!pick_found && req[i] && PW'(i) >= rr_ptr) begin
                win_nxt    = PW'(i);
                pick_found = 1'b1;
            end
        end
`endif
        for (int i = 1; i < NUM_PORTS; i++) begin
            if (!pick_found && req[i]) begin
                win_nxt    = PW'(i);
                pick_found = 1'b1;
            end
        end
        if (req[0]) begin
            win_nxt = '0;
        end
    end

    // Requesters hold their operands until gnt, so the winner's live inputs feed the RAM.
    always_comb begin
        addr_sel  = addr[int'(win_idx) * ADDR_W +: ADDR_W];
        wdata_sel = wdata[int'(win_idx) * DATA_W +: DATA_W];
        we_sel    = we[win_idx];
        oob_sel   = ({1'b0, addr_sel} >= DEPTH_L);
    end

    // A reset during GRANT suppresses the RAM cycle so a pending write is dropped.
    assign ram_en = (state == GRANT) && !reset;
    assign ram_we = ram_en && we_sel && !oob_sel;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_sel[MEM_AW-1:0]),
        .wdata (wdata_sel),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_idx    <= '0;
            rd_oob     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                win_idx <= win_nxt;
            end
            if (state == GRANT) begin
                rd_oob <= oob_sel;
            end
            if (state == RDATA) begin
                rdata_hold <= rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rvalid    = '0;
        rdata     = rdata_hold;
        unique case (state)
            IDLE: begin
                if (enable && |req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                gnt[win_idx] = 1'b1;
                state_nxt    = we_sel ? IDLE : RDATA;
            end
            RDATA: begin
                rvalid[win_idx] = 1'b1;
                rdata           = rd_oob ? '0 : ram_q;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs read as idle for the whole reset cycle, including a reset mid-access.
        if (reset) begin
            gnt    = '0;
            rvalid = '0;
            rdata  = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic scored against a transaction-level model.
module tb_mem_arbiter;

    localparam int NP    = 3;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    typedef struct {
        bit            en;
        logic [NP-1:0] rq;
        logic [NP-1:0] w;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] wd;
        logic [NP-1:0] g;
        logic [NP-1:0] rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit en, logic [NP-1:0] rq, logic [NP-1:0] w,
                                logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2,
                                logic [DW-1:0] wd, logic [NP-1:0] g, logic [NP-1:0] rv,
                                logic [DW-1:0] rd);
        vec_t v;
        v.en = en; v.rq = rq; v.w = w;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd = wd;
        v.g = g; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    function automatic logic [NP-1:0] oh(int p);
        return NP'(1) << p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = r;
        we[p]  = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_port(p, 1'b1, 1'b1, a, d);
        @(negedge clk);
        chk("wr_idle", 32'({gnt, rvalid}), 32'(0));
        next_cycle();
        @(negedge clk);
        chk("wr_gnt", 32'({gnt, rvalid}), 32'({oh(p), 3'b000}));
        next_cycle();
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        set_port(p, 1'b1, 1'b0, a, '0);
        @(negedge clk);
        chk("rd_idle", 32'({gnt, rvalid}), 32'(0));
        next_cycle();
        @(negedge clk);
        chk("rd_gnt", 32'({gnt, rvalid}), 32'({oh(p), 3'b000}));
        next_cycle();
        set_port(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rd_data", 32'({gnt, rvalid, rdata}), 32'({3'b000, oh(p), exp}));
        next_cycle();
    endtask

    // Model state for the randomized phase
    bit            pend [NP];
    bit            pw   [NP];
    logic [AW-1:0] pa   [NP];
    logic [DW-1:0] pd   [NP];
    logic [DW-1:0] mmem   [DEPTH];
    bit            mknown [DEPTH];
    logic [AW-1:0] pool [12];

    initial begin
        logic [NP-1:0] gf, gs;
        logic [DW-1:0] df, ds;
        int prev, ng, cur, exp_port;
        int gnt_at, rv_at, idle_from, win, rv_port, rr_next, npend;
        logic [DW-1:0] rv_data, last;
        bit rv_known, last_known, found;
        logic [NP-1:0] eg, er;

        reset = 1'b1; enable = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_out", 32'({gnt, rvalid, rdata}), 32'(0));
        next_cycle();
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("post_reset_out", 32'({gnt, rvalid, rdata}), 32'(0));
        next_cycle();

        // First of ports 1/2 served after video depends on the arbitration rule.
        gf = RR ? 3'b100 : 3'b010;
        gs = RR ? 3'b010 : 3'b100;
        df = RR ? 16'hBEEF : 16'h0000;
        ds = RR ? 16'h0000 : 16'hBEEF;

        tbl.push_back(mk(1, 3'b010, 3'b010, 0, 15'h10, 0, 16'hBEEF, 3'b000, 3'b000, 16'h0000));
        tbl.push_back(mk(1, 3'b010, 3'b010, 0, 15'h10, 0, 16'hBEEF, 3'b010, 3'b000, 16'h0000));
        tbl.push_back(mk(1, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b000, 3'b000, 16'h0000));
        tbl.push_back(mk(1, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b010, 3'b000, 16'h0000));
        tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, 3'b010, 16'hBEEF));
        tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, 3'b000, 16'hBEEF));
        tbl.push_back(mk(1, 3'b111, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b000, 3'b000, 16'hBEEF));
        tbl.push_back(mk(1, 3'b111, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b001, 3'b000, 16'hBEEF));
        tbl.push_back(mk(1, 3'b110, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b000, 3'b001, 16'hBEEF));
        tbl.push_back(mk(1, 3'b110, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b000, 3'b000, 16'hBEEF));
        tbl.push_back(mk(1, 3'b110, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, gf, 3'b000, 16'hBEEF));
        tbl.push_back(mk(1, gs, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b000, gf, df));
        tbl.push_back(mk(1, gs, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, 3'b000, 3'b000, df));
        tbl.push_back(mk(1, gs, 3'b000, 15'h10, 15'h7FFF, 15'h10, 16'h0, gs, 3'b000, df));
        tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, gs, ds));
        tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, 3'b000, ds));
        tbl.push_back(mk(0, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b000, 3'b000, ds));
        tbl.push_back(mk(0, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b000, 3'b000, ds));
        tbl.push_back(mk(1, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b000, 3'b000, ds));
        tbl.push_back(mk(0, 3'b010, 3'b000, 0, 15'h10, 0, 16'h0, 3'b010, 3'b000, ds));
        tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, 3'b010, 16'hBEEF));
        tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 16'h0, 3'b000, 3'b000, 16'hBEEF));

        for (int k = 0; k < tbl.size(); k++) begin
            enable = tbl[k].en;
            req    = tbl[k].rq;
            we     = tbl[k].w;
            addr   = {tbl[k].a2, tbl[k].a1, tbl[k].a0};
            wdata  = {tbl[k].wd, tbl[k].wd, tbl[k].wd};
            @(negedge clk);
            chk($sformatf("vec%0d", k), 32'({gnt, rvalid, rdata}),
                32'({tbl[k].g, tbl[k].rv, tbl[k].rd}));
            next_cycle();
        end
        enable = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;

        // Out-of-range write must not alias into the implemented array
        do_write(1, 15'h0FFF, 16'h1234);
        do_write(1, 15'h7FFF, 16'hDEAD);
        do_read(1, 15'h0FFF, 16'h1234);
        do_read(0, 15'h7FFF, 16'h0000);

        // Reset asserted in the GRANT cycle of a read
        do_write(2, 15'h0020, 16'hCAFE);
        set_port(2, 1'b1, 1'b0, 15'h0020, '0);
        @(negedge clk);
        chk("rst_idle", 32'({gnt, rvalid}), 32'(0));
        next_cycle();
        reset = 1'b1;
        set_port(2, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst_in_grant", 32'({gnt, rvalid, rdata}), 32'(0));
        next_cycle();
        reset = 1'b0;
        set_port(2, 1'b1, 1'b0, 15'h0020, '0);
        @(negedge clk);
        chk("rst_release", 32'({gnt, rvalid, rdata}), 32'(0));
        next_cycle();
        @(negedge clk);
        chk("rst_regrant", 32'({gnt, rvalid}), 32'({3'b100, 3'b000}));
        next_cycle();
        set_port(2, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rst_data_intact", 32'({gnt, rvalid, rdata}), 32'({3'b000, 3'b100, 16'hCAFE}));
        next_cycle();

        // Ports 1 and 2 requesting continuously for four grants
        set_port(1, 1'b1, 1'b0, 15'h0FFF, '0);
        set_port(2, 1'b1, 1'b0, 15'h0020, '0);
        prev = 0;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                cur = (gnt == 3'b010) ? 1 : ((gnt == 3'b100) ? 2 : 9);
                exp_port = (RR && prev > 0) ? 3 - prev : 1;
                chk("cont_grant_port", 32'(cur), 32'(exp_port));
                prev = cur;
                ng++;
            end
            if (rvalid != '0) begin
                chk("cont_rdata", 32'(rdata), (rvalid == 3'b010) ? 32'h1234 : 32'hCAFE);
            end
            next_cycle();
        end
        set_port(1, 1'b0, 1'b0, '0, '0);
        set_port(2, 1'b0, 1'b0, '0, '0);
        chk("cont_grant_count", 32'(ng), 32'(4));

        // Clean reset so the model starts from a known pointer and rdata
        reset = 1'b1;
        @(negedge clk);
        chk("reset2_out", 32'({gnt, rvalid, rdata}), 32'(0));
        next_cycle();
        reset = 1'b0;

        pool = '{15'h0, 15'h1, 15'h2, 15'h3, 15'h4, 15'h5, 15'h6, 15'h7,
                 15'h10, 15'h20, 15'h7FFF, 15'h1000};
        mmem[16'h10]  = 16'hBEEF; mknown[16'h10]  = 1'b1;
        mmem[16'hFFF] = 16'h1234; mknown[16'hFFF] = 1'b1;
        mmem[16'h20]  = 16'hCAFE; mknown[16'h20]  = 1'b1;
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        gnt_at = -1; rv_at = -1; idle_from = 0; win = 0; rv_port = 0; rr_next = 1;
        rv_data = '0; rv_known = 1'b0; last = '0; last_known = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 35) begin
                    pend[p] = 1'b1;
                    pw[p]   = ($urandom_range(0, 2) == 0);
                    pa[p]   = pool[$urandom_range(0, 11)];
                    pd[p]   = DW'($urandom());
                end
                set_port(p, pend[p], pend[p] & pw[p], pa[p], pd[p]);
            end
            enable = ($urandom_range(0, 9) != 0);

            eg = '0;
            er = '0;
            if (c == gnt_at) begin
                eg = oh(win);
                if (pw[win]) begin
                    if (int'(pa[win]) < DEPTH) begin
                        mmem[int'(pa[win])]   = pd[win];
                        mknown[int'(pa[win])] = 1'b1;
                    end
                    idle_from = c + 1;
                end else begin
                    rv_at   = c + 1;
                    rv_port = win;
                    if (int'(pa[win]) >= DEPTH) begin
                        rv_data  = '0;
                        rv_known = 1'b1;
                    end else begin
                        rv_data  = mmem[int'(pa[win])];
                        rv_known = mknown[int'(pa[win])];
                    end
                    idle_from = c + 2;
                end
            end
            if (c == rv_at) begin
                er         = oh(rv_port);
                last       = rv_data;
                last_known = rv_known;
            end
            npend = 0;
            for (int p = 0; p < NP; p++) npend += int'(pend[p]);
            if (c >= idle_from && gnt_at < c && enable && npend > 0) begin
                found = 1'b0;
                if (pend[0]) begin
                    win   = 0;
                    found = 1'b1;
                end
                for (int k = 0; k < NP - 1; k++) begin
                    int p;
                    p = RR ? 1 + ((rr_next - 1 + k) % (NP - 1)) : 1 + k;
                    if (!found && pend[p]) begin
                        win   = p;
                        found = 1'b1;
                    end
                end
                if (win != 0) rr_next = (win == NP - 1) ? 1 : win + 1;
                gnt_at = c + 1;
            end

            @(negedge clk);
            chk("rand_ctl", 32'({gnt, rvalid}), 32'({eg, er}));
            if (last_known) chk("rand_rdata", 32'(rdata), 32'(last));
            next_cycle();
            if (c == gnt_at) pend[win] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
